// File: rtl/clk_count_pkg.sv
// ---------------------------------------------------------------------------
// clk_count_pkg
// Shared definitions for the digital-clock time-unit counters:
//   - clog2 helper for sizing counters from parameters
//   - default clock rate and digit-group moduli
//   - step encoding used between request decode and value update
// ---------------------------------------------------------------------------
package clk_count_pkg;

  localparam int CLK_HZ  = 32'd1000;
  localparam int SEC_MOD = 32'd60;
  localparam int MIN_MOD = 32'd60;
  localparam int HR_MOD  = 32'd24;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DN   = 2'd2
  } step_t;

  // Number of bits needed to hold values 0..val-1 (0 for val <= 1).
  function automatic int clog2(input int val);
    int res;
    res = 32'd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < val) begin
        res = i + 32'd1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/clk_count_unit_prescaler.sv
// ---------------------------------------------------------------------------
// clk_prescaler
// Divides the base clock into a one-cycle unit tick every DIV enabled cycles.
// Ports:
//   CLK    base clock
//   rst_n  asynchronous active-low reset (pcnt -> 0)
//   clr    synchronous clear of pcnt
//   en     advance enable; 0 freezes pcnt and suppresses tick
//   tick   combinational, en & (pcnt == DIV-1)
// ---------------------------------------------------------------------------
module clk_prescaler
  import clk_count_pkg::*;
#(
  parameter int DIV = 1000
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  // DIV=1 still gets a 1-bit counter that simply stays at 0, so tick = en.
  localparam int PW = (DIV > 1) ? clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pcnt_r;
  logic          at_last_s;

  assign at_last_s = (pcnt_r == LAST);
  assign tick      = en & at_last_s;

  // Prescale counter: clear has priority, wraps on the tick cycle.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_r <= {PW{1'b0}};
    end else if (clr) begin
      pcnt_r <= {PW{1'b0}};
    end else if (tick) begin
      pcnt_r <= {PW{1'b0}};
    end else if (en) begin
      pcnt_r <= pcnt_r + PW'(1);
    end else begin
      pcnt_r <= pcnt_r;
    end
  end

endmodule

// File: rtl/clk_count_unit.sv
// ---------------------------------------------------------------------------
// clk_count_unit
// Modulo-MODULUS time-unit counter with optional internal prescaler,
// up/down counting, manual encoder steps, range-checked parallel load and
// carry/borrow outputs for chaining into the next stage's en_step.
// Ports:
//   CLK, rst_n      base clock, asynchronous active-low reset
//   rst_counters    synchronous clear of prescaler and value
//   en              prescaler advance enable (PRESCALE_EN=1)
//   en_step         external step pulse (PRESCALE_EN=0)
//   dir_down        tick direction, 1 = count down
//   enc_inc/enc_dec manual +1 / -1 pulses
//   load, load_val  parallel load strobe and value
//   value           registered count
//   tick            unit tick (combinational)
//   carry/borrow    combinational wrap indicators, aligned with the request
//   load_err        registered one-cycle pulse after a rejected load
// ---------------------------------------------------------------------------
module clk_count_unit
  import clk_count_pkg::*;
#(
  parameter int DIV         = 1000,
  parameter int MODULUS     = 60,
  parameter int WIDTH       = 8,
  parameter int PRESCALE_EN = 1
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             rst_counters,
  input  logic             en,
  input  logic             en_step,
  input  logic             dir_down,
  input  logic             enc_inc,
  input  logic             enc_dec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] value,
  output logic             tick,
  output logic             carry,
  output logic             borrow,
  output logic             load_err
);

  if (DIV < 1) begin : g_bad_div
    $error("clk_count_unit: DIV must be >= 1");
  end
  if (MODULUS < 2) begin : g_bad_mod_lo
    $error("clk_count_unit: MODULUS must be >= 2");
  end
  if (64'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_mod_hi
    $error("clk_count_unit: MODULUS must not exceed 2**WIDTH");
  end

  // MODULUS may equal 2**WIDTH, so the bound is compared one bit wider.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic             tick_s;
  logic             up_req_s;
  logic             dn_req_s;
  step_t            step_s;
  logic             load_ok_s;
  logic [WIDTH-1:0] value_nxt_s;
  logic             load_err_nxt_s;
  logic             carry_s;
  logic             borrow_s;
  logic [WIDTH-1:0] value_r;
  logic             load_err_r;

  if (PRESCALE_EN != 0) begin : g_pre
    logic unused_en_step_s;
    assign unused_en_step_s = en_step;

    clk_prescaler #(
      .DIV (DIV)
    ) u_prescaler (
      .CLK   (CLK),
      .rst_n (rst_n),
      .clr   (rst_counters),
      .en    (en),
      .tick  (tick_s)
    );
  end else begin : g_nopre
    logic unused_en_s;
    assign unused_en_s = en;
    assign tick_s      = en_step;
  end

  assign up_req_s  = enc_inc | (tick_s & ~dir_down);
  assign dn_req_s  = enc_dec | (tick_s & dir_down);
  assign load_ok_s = ({1'b0, load_val} < MOD_EXT);

  // Step decode: coincident same-direction sources collapse, opposing cancel.
  always_comb begin
    step_s = STEP_NONE;
    case ({up_req_s, dn_req_s})
      2'b10:   step_s = STEP_UP;
      2'b01:   step_s = STEP_DN;
      default: step_s = STEP_NONE;
    endcase
  end

  // Next value with priority clear > load > step; wraps flag carry/borrow.
  always_comb begin
    value_nxt_s    = value_r;
    load_err_nxt_s = 1'b0;
    carry_s        = 1'b0;
    borrow_s       = 1'b0;
    if (rst_counters) begin
      value_nxt_s = {WIDTH{1'b0}};
    end else if (load) begin
      if (load_ok_s) begin
        value_nxt_s = load_val;
      end else begin
        load_err_nxt_s = 1'b1;
      end
    end else begin
      case (step_s)
        STEP_UP: begin
          if (value_r == MAX_VAL) begin
            value_nxt_s = {WIDTH{1'b0}};
            carry_s     = 1'b1;
          end else begin
            value_nxt_s = value_r + WIDTH'(1);
          end
        end
        STEP_DN: begin
          if (value_r == {WIDTH{1'b0}}) begin
            value_nxt_s = MAX_VAL;
            borrow_s    = 1'b1;
          end else begin
            value_nxt_s = value_r - WIDTH'(1);
          end
        end
        STEP_NONE: value_nxt_s = value_r;
        default:   value_nxt_s = value_r;
      endcase
    end
  end

  // Count and load-error registers.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      value_r    <= {WIDTH{1'b0}};
      load_err_r <= 1'b0;
    end else begin
      value_r    <= value_nxt_s;
      load_err_r <= load_err_nxt_s;
    end
  end

  assign value    = value_r;
  assign load_err = load_err_r;
  assign tick     = tick_s;
  assign carry    = carry_s;
  assign borrow   = borrow_s;

endmodule

// File: tb/tb_clk_count_unit.sv
// ---------------------------------------------------------------------------
// tb_clk_count_unit
// Directed bench: main DIV=4/MOD=60 unit, a MOD=24 unit stepped externally,
// and a seconds->minutes cascade. Inputs change 1 time unit after posedge;
// combinational outputs are sampled on the negedge.
// ---------------------------------------------------------------------------
module tb_clk_count_unit;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       rst_n, rst_counters, en, dir_down, enc_inc, enc_dec, load;
  logic [7:0] load_val, value;
  logic       tick, carry, borrow, load_err;

  logic       h_step, h_dir, h_load;
  logic [7:0] h_lv, h_value;
  logic       h_tick, h_carry, h_borrow, h_lerr;

  logic       s_en, s_load, m_load;
  logic [7:0] s_lv, s_value, m_value;
  logic       s_tick, s_carry, s_borrow, s_lerr;
  logic       m_tick, m_carry, m_borrow, m_lerr;

  int n_chk  = 0;
  int n_pass = 0;

  clk_count_unit #(.DIV(4), .MODULUS(60), .WIDTH(8), .PRESCALE_EN(1)) dut (
    .CLK(CLK), .rst_n(rst_n), .rst_counters(rst_counters), .en(en),
    .en_step(1'b0), .dir_down(dir_down), .enc_inc(enc_inc), .enc_dec(enc_dec),
    .load(load), .load_val(load_val), .value(value), .tick(tick),
    .carry(carry), .borrow(borrow), .load_err(load_err));

  clk_count_unit #(.DIV(1), .MODULUS(24), .WIDTH(8), .PRESCALE_EN(0)) u_hr (
    .CLK(CLK), .rst_n(rst_n), .rst_counters(1'b0), .en(1'b0),
    .en_step(h_step), .dir_down(h_dir), .enc_inc(1'b0), .enc_dec(1'b0),
    .load(h_load), .load_val(h_lv), .value(h_value), .tick(h_tick),
    .carry(h_carry), .borrow(h_borrow), .load_err(h_lerr));

  clk_count_unit #(.DIV(1000), .MODULUS(60), .WIDTH(8), .PRESCALE_EN(1)) u_sec (
    .CLK(CLK), .rst_n(rst_n), .rst_counters(1'b0), .en(s_en),
    .en_step(1'b0), .dir_down(1'b0), .enc_inc(1'b0), .enc_dec(1'b0),
    .load(s_load), .load_val(s_lv), .value(s_value), .tick(s_tick),
    .carry(s_carry), .borrow(s_borrow), .load_err(s_lerr));

  clk_count_unit #(.DIV(1), .MODULUS(60), .WIDTH(8), .PRESCALE_EN(0)) u_min (
    .CLK(CLK), .rst_n(rst_n), .rst_counters(1'b0), .en(1'b0),
    .en_step(s_carry), .dir_down(1'b0), .enc_inc(1'b0), .enc_dec(1'b0),
    .load(m_load), .load_val(s_lv), .value(m_value), .tick(m_tick),
    .carry(m_carry), .borrow(m_borrow), .load_err(m_lerr));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_main(input logic [7:0] v);
    load = 1'b1; load_val = v;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; rst_counters = 1'b0; en = 1'b0; dir_down = 1'b0;
    enc_inc = 1'b0; enc_dec = 1'b0; load = 1'b0; load_val = 8'd0;
    h_step = 1'b0; h_dir = 1'b0; h_load = 1'b0; h_lv = 8'd0;
    s_en = 1'b0; s_load = 1'b0; m_load = 1'b0; s_lv = 8'd0;

    // Reset state
    #2;
    check("rst_value", value, 0);
    check("rst_tick", tick, 0);
    check("rst_carry", carry, 0);
    check("rst_borrow", borrow, 0);
    check("rst_load_err", load_err, 0);
    #10 rst_n = 1'b1;
    cyc();

    // Free-running count up, DIV=4, 240 cycles
    en = 1'b1;
    for (int k = 0; k < 240; k++) begin
      @(negedge CLK);
      check("run_value", value, (k / 4) % 60);
      check("run_tick", tick, (k % 4) == 3);
      check("run_carry", carry, k == 239);
      check("run_borrow", borrow, 0);
      cyc();
    end
    en = 1'b0;
    check("run_wrap_value", value, 0);

    // enc_inc coinciding with tick at 59: one step, one carry
    load_main(8'd59);
    check("load59", value, 59);
    en = 1'b1;
    cyc(); cyc(); cyc();
    enc_inc = 1'b1;
    @(negedge CLK);
    check("coinc_tick", tick, 1);
    check("coinc_carry", carry, 1);
    cyc();
    enc_inc = 1'b0; en = 1'b0;
    check("coinc_value", value, 0);
    @(negedge CLK);
    check("coinc_carry_gone", carry, 0);

    // Opposing manual steps cancel; single steps move by one
    load_main(8'd10);
    enc_inc = 1'b1; enc_dec = 1'b1;
    cyc();
    check("cancel_value", value, 10);
    enc_dec = 1'b0;
    cyc();
    check("inc_value", value, 11);
    enc_inc = 1'b0; enc_dec = 1'b1;
    cyc();
    enc_dec = 1'b0;
    check("dec_value", value, 10);

    // Count down through zero
    load_main(8'd0);
    dir_down = 1'b1; en = 1'b1;
    cyc(); cyc(); cyc();
    @(negedge CLK);
    check("down_tick", tick, 1);
    check("down_borrow", borrow, 1);
    check("down_carry", carry, 0);
    cyc();
    en = 1'b0; dir_down = 1'b0;
    check("down_value", value, 59);

    // Loads: in range, out of range, and load beating a tick at 59
    load_main(8'd45);
    check("load45", value, 45);
    load_main(8'd60);
    check("load60_value", value, 45);
    check("load60_err", load_err, 1);
    cyc();
    check("load_err_pulse", load_err, 0);
    load_main(8'd59);
    en = 1'b1;
    cyc(); cyc(); cyc();
    load = 1'b1; load_val = 8'd7;
    @(negedge CLK);
    check("ldtick_tick", tick, 1);
    check("ldtick_carry", carry, 0);
    cyc();
    load = 1'b0; en = 1'b0;
    check("ldtick_value", value, 7);
    check("ldtick_err", load_err, 0);

    // rst_counters mid-count (pcnt=2, value=33)
    load_main(8'd33);
    en = 1'b1;
    cyc(); cyc();
    rst_counters = 1'b1;
    @(negedge CLK);
    check("clr_tick", tick, 0);
    cyc();
    rst_counters = 1'b0;
    check("clr_value", value, 0);
    for (int j = 0; j < 4; j++) begin
      @(negedge CLK);
      check("clr_tick_phase", tick, j == 3);
      cyc();
    end
    en = 1'b0;
    check("clr_next_value", value, 1);

    // rst_counters in a wrapping tick cycle: no carry, value 0
    load_main(8'd59);
    en = 1'b1;
    cyc(); cyc(); cyc();
    rst_counters = 1'b1;
    @(negedge CLK);
    check("clrwrap_tick", tick, 1);
    check("clrwrap_carry", carry, 0);
    cyc();
    rst_counters = 1'b0; en = 1'b0;
    check("clrwrap_value", value, 0);

    // MODULUS=24 unit: 0 -> 23 on down step, 23 -> 0 on up step
    h_dir = 1'b1; h_step = 1'b1;
    @(negedge CLK);
    check("hr_tick", h_tick, 1);
    check("hr_borrow", h_borrow, 1);
    check("hr_carry_dn", h_carry, 0);
    cyc();
    h_dir = 1'b0;
    check("hr_value23", h_value, 23);
    @(negedge CLK);
    check("hr_carry", h_carry, 1);
    cyc();
    h_step = 1'b0;
    check("hr_value0", h_value, 0);
    h_load = 1'b1; h_lv = 8'd24;
    cyc();
    h_load = 1'b0;
    check("hr_load24_err", h_lerr, 1);
    check("hr_load24_value", h_value, 0);

    // Cascade seconds -> minutes at 59:59
    s_load = 1'b1; m_load = 1'b1; s_lv = 8'd59;
    cyc();
    s_load = 1'b0; m_load = 1'b0;
    check("casc_sec59", s_value, 59);
    check("casc_min59", m_value, 59);
    s_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 1100 && !found; i++) begin
      @(negedge CLK);
      if (s_tick) begin
        found = 1'b1;
        check("casc_tick_cycle", i, 999);
        check("casc_sec_carry", s_carry, 1);
        check("casc_min_carry", m_carry, 1);
        cyc();
        check("casc_sec_value", s_value, 0);
        check("casc_min_value", m_value, 0);
      end else begin
        cyc();
      end
    end
    s_en = 1'b0;
    check("casc_found", found, 1);

    // Asynchronous reset mid-cycle
    load_main(8'd33);
    check("async_pre", value, 33);
    @(negedge CLK);
    #2 rst_n = 1'b0;
    #1;
    check("async_value", value, 0);
    check("async_load_err", load_err, 0);
    check("async_min_value", m_value, 0);
    @(negedge CLK);
    rst_n = 1'b1;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/clk_count_unit.md
Name: clk_count_unit

Overview:
Parametrised time-unit counter: a prescaler turns the base clock into a unit tick, and a modulo-N counter advances on that tick. It adds up/down mode, manual inc/dec, parallel load with range check, and carry/borrow chaining. One instance per digit group (seconds, minutes, hours, countdown timer) in the digital-clock datapath, chained through carry/borrow into the next instance's en_step.

Parameters:
- DIV, 1000, base-clock cycles per unit tick (1 = tick on every enabled cycle); legal range 1..65535.
- MODULUS, 60, count range 0..MODULUS-1; legal range 2..2**WIDTH.
- WIDTH, 8, width of the count value.
- PRESCALE_EN, 1, 1 = internal prescaler used; 0 = prescaler removed, tick = en_step.

Ports:
- CLK  in  1  base clock (1 kHz in the clock product).
- rst_n  in  1  asynchronous active-low reset.
- rst_counters  in  1  synchronous clear of prescaler and value.
- en  in  1  prescaler advance enable.
- en_step  in  1  external step pulse; used only when PRESCALE_EN=0 (cascade input from the previous stage).
- dir_down  in  1  0 = tick counts up, 1 = tick counts down.
- enc_inc  in  1  manual +1 pulse (encoder).
- enc_dec  in  1  manual -1 pulse (encoder).
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value to load.
- value  out  WIDTH  current count (registered).
- tick  out  1  unit tick, combinational, one cycle wide.
- carry  out  1  combinational; high in the cycle value wraps MODULUS-1 -> 0.
- borrow  out  1  combinational; high in the cycle value wraps 0 -> MODULUS-1.
- load_err  out  1  registered one-cycle pulse after a rejected load.

Behaviour:
- Reset (rst_n low, asynchronous): prescaler = 0, value = 0, load_err = 0. tick, carry and borrow are therefore 0.
- Prescaler (PRESCALE_EN=1):
  - pcnt advances only when en=1.
  - tick = en & (pcnt == DIV-1). pcnt wraps to 0 on that cycle.
  - en=0 freezes pcnt and forces tick=0.
  - DIV=1: tick = en.
- PRESCALE_EN=0: tick = en_step; no prescaler registers are built.
- Step requests:
  - up_req = enc_inc | (tick & ~dir_down)
  - dn_req = enc_dec | (tick & dir_down)
  - up_req & ~dn_req gives step +1; dn_req & ~up_req gives step -1; otherwise hold.
  - Coincident same-direction sources count once. Opposing sources cancel.
- Value priority, highest first:
  1. rst_counters: value = 0 and pcnt = 0. carry and borrow stay 0 this cycle.
  2. load: if load_val < MODULUS, value = load_val; otherwise value is unchanged and load_err pulses on the next cycle. Step requests are ignored during a load. Load does not touch pcnt.
  3. Step +1: value = (value == MODULUS-1) ? 0 : value+1; carry = 1 on the wrap.
  4. Step -1: value = (value == 0) ? MODULUS-1 : value-1; borrow = 1 on the wrap.
- carry and borrow are never asserted in the same cycle.
- Latency: value updates on the CLK edge after the request. carry and borrow align with the request cycle, so a downstream stage's en_step steps on the same edge as this stage's wrap.
- Arithmetic: compare and wrap at full WIDTH. No transient out-of-range value is ever registered.
- Elaboration error if MODULUS > 2**WIDTH, MODULUS < 2, or DIV < 1.

Decomposition:
- Shared package clk_count_pkg:
  - clog2 function.
  - Default constants: CLK_HZ = 1000, SEC_MOD = 60, MIN_MOD = 60, HR_MOD = 24.
  - Step encoding constants: STEP_NONE, STEP_UP, STEP_DN.
- Sub-module clk_prescaler (params DIV; ports CLK, rst_n, clr, en, tick), instantiated only when PRESCALE_EN=1.

Test Plan:
- DIV=4, MODULUS=60, en=1 held, dir_down=0, 240 cycles -> value steps every 4th cycle to 59, then 0 with carry high exactly one cycle; tick period 4.
- value=59, enc_inc and tick coincide -> value=0, single carry, no double step. value=10, enc_inc & enc_dec together -> value stays 10.
- dir_down=1, value=0, tick -> value=59 and borrow=1 that cycle. MODULUS=24 instance at 0 -> 23.
- load_val=45 -> value=45 next cycle. load_val=60 -> value unchanged, load_err=1 for one cycle. load coinciding with tick -> load wins.
- Mid-count (pcnt=2, value=33): rst_counters pulse -> value=0, pcnt=0, next tick 4 cycles later. rst_n asserted mid-cycle -> outputs 0 immediately, asynchronously.
- Cascade: seconds (DIV=1000) carry into minutes instance (PRESCALE_EN=0, en_step=carry). At 59:59 -> both read 00 on the same edge, minutes carry asserted.
